// File: rtl/rf_wb_arbiter_if.sv
// Writeback bundle between the requesters and the register-file write arbiter.
// With RF_WB_FWD_EN defined, also carries the two forwarding compare ports.
interface rf_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      wb_hold;
  logic                      reg_write;
  logic [ADDR_W-1:0]         reg_in_addr;
  logic [DATA_W-1:0]         reg_data_in;
  logic                      busy;
`ifdef RF_WB_FWD_EN
  logic [ADDR_W-1:0]         fwd_addr1;
  logic [ADDR_W-1:0]         fwd_addr2;
  logic                      fwd_hit1;
  logic                      fwd_hit2;
  logic [DATA_W-1:0]         fwd_data1;
  logic [DATA_W-1:0]         fwd_data2;

  modport master (
    output req_valid, req_addr, req_data, wb_hold, fwd_addr1, fwd_addr2,
    input  req_ready, reg_write, reg_in_addr, reg_data_in, busy,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
  modport slave (
    input  req_valid, req_addr, req_data, wb_hold, fwd_addr1, fwd_addr2,
    output req_ready, reg_write, reg_in_addr, reg_data_in, busy,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
`else
  modport master (
    output req_valid, req_addr, req_data, wb_hold,
    input  req_ready, reg_write, reg_in_addr, reg_data_in, busy
  );
  modport slave (
    input  req_valid, req_addr, req_data, wb_hold,
    output req_ready, reg_write, reg_in_addr, reg_data_in, busy
  );
`endif
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port; the
// granted write is registered and issued one cycle later. RF_WB_FWD_EN adds forwarding.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic           clk,
  input  logic           reset,
  rf_wb_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [PTR_W:0]     cand;
  logic               handshake;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan upward from the pointer, wrapping modulo NUM_REQ; first valid wins.
  always_comb begin
    grant     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!win_found && bus.req_valid[cand[PTR_W-1:0]]) begin
        win_found                  = 1'b1;
        win_idx                    = cand[PTR_W-1:0];
        grant[cand[PTR_W-1:0]]     = 1'b1;
      end
    end
  end

  assign bus.req_ready = (reset || bus.wb_hold) ? '0 : grant;
  assign handshake     = |(bus.req_valid & bus.req_ready);

  always_comb begin
    ptr_d       = ptr_q;
    reg_write_d = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    if (handshake) begin
      addr_d      = addr_arr[win_idx];
      data_d      = data_arr[win_idx];
      // Address 0 is accepted but never written.
      reg_write_d = |addr_arr[win_idx];
      ptr_d       = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      reg_write_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      reg_write_q <= reg_write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign bus.reg_write   = reg_write_q;
  assign bus.reg_in_addr = addr_q;
  assign bus.reg_data_in = data_q;
  assign bus.busy        = (|bus.req_valid) | reg_write_q;

`ifdef RF_WB_FWD_EN
  // Readers of the register being written this cycle get the in-flight value.
  assign bus.fwd_hit1  = reg_write_q && (addr_q == bus.fwd_addr1) && (|bus.fwd_addr1);
  assign bus.fwd_hit2  = reg_write_q && (addr_q == bus.fwd_addr2) && (|bus.fwd_addr2);
  assign bus.fwd_data1 = bus.fwd_hit1 ? data_q : '0;
  assign bus.fwd_data2 = bus.fwd_hit2 ? data_q : '0;
`endif
endmodule
